// File: rtl/cable_launch_ctrl.sv
// cable_launch_ctrl: launches the cable, turns pixel overlap into one reverse pulse per extension, delivers grabbed item value
module cable_launch_ctrl #(
  parameter int HOME_X                = 280,
  parameter int HOME_Y                = 185,
  parameter int LAUNCH_TIMEOUT_FRAMES = 4,
  parameter int MAX_EXTEND_FRAMES     = 400,
  parameter int MAX_RETRACT_FRAMES    = 450
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               launch_key,
  input  logic signed [10:0] cableX,
  input  logic signed [10:0] cableY,
  input  logic               drawReq_cable,
  input  logic               drawReq_border,
  input  logic               drawReq_item,
  input  logic [7:0]         item_value,
  output logic               launch_Cable,
  output logic               collision,
  output logic               grabbed,
  output logic               score_valid,
  output logic [7:0]         score_add,
  output logic               timeout_err,
  output logic [2:0]         state_dbg
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    EXTEND  = 3'd2,
    RETRACT = 3'd3,
    DELIVER = 3'd4
  } state_t;
  localparam logic signed [10:0] HX = 11'(HOME_X);
  localparam logic signed [10:0] HY = 11'(HOME_Y);
  localparam logic [9:0] LT = 10'(LAUNCH_TIMEOUT_FRAMES);
  localparam logic [9:0] ME = 10'(MAX_EXTEND_FRAMES);
  localparam logic [9:0] MR = 10'(MAX_RETRACT_FRAMES);
  state_t      state_q;
  logic        key_prev_q, hit_item_q, hit_border_q;
  logic [7:0]  cap_q, item_q;
  logic [9:0]  frame_cnt_q;
  logic        home, key_rise, item_px, border_px;
  assign home      = (cableX == HX) && (cableY == HY);
  assign key_rise  = launch_key && !key_prev_q;
  assign item_px   = drawReq_cable && drawReq_item;
  assign border_px = drawReq_cable && drawReq_border;
  assign state_dbg = state_q;
  // per-frame overlap latches: only armed while extending, cleared each frame after the FSM has sampled them
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_item_q   <= 1'b0;
      hit_border_q <= 1'b0;
      cap_q        <= 8'd0;
    end else if (startOfFrame || state_q != EXTEND) begin
      hit_item_q   <= 1'b0;
      hit_border_q <= 1'b0;
    end else begin
      if (item_px) hit_item_q <= 1'b1;
      if (item_px && !hit_item_q) cap_q <= item_value;
      if (border_px) hit_border_q <= 1'b1;
    end
  end
  // control FSM with registered outputs; every transition also restarts the frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      key_prev_q   <= 1'b0;
      frame_cnt_q  <= 10'd0;
      item_q       <= 8'd0;
      launch_Cable <= 1'b0;
      collision    <= 1'b0;
      grabbed      <= 1'b0;
      score_valid  <= 1'b0;
      score_add    <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      key_prev_q  <= launch_key;
      collision   <= 1'b0;
      score_valid <= 1'b0;
      score_add   <= 8'd0;
      frame_cnt_q <= (startOfFrame && frame_cnt_q != 10'h3ff) ? frame_cnt_q + 10'd1 : frame_cnt_q;
      case (state_q)
        IDLE: begin
          if (key_rise && home) begin
            state_q      <= LAUNCH;
            launch_Cable <= 1'b1;
            frame_cnt_q  <= 10'd0;
          end
        end
        LAUNCH: begin
          if (!home) begin
            state_q      <= EXTEND;
            launch_Cable <= 1'b0;
            frame_cnt_q  <= 10'd0;
          end else if (frame_cnt_q >= LT) begin
            state_q      <= IDLE;
            launch_Cable <= 1'b0;
            frame_cnt_q  <= 10'd0;
          end
        end
        EXTEND: begin
          if (startOfFrame && (hit_item_q || hit_border_q)) begin
            state_q     <= RETRACT;
            collision   <= 1'b1;
            grabbed     <= hit_item_q;
            item_q      <= hit_item_q ? cap_q : item_q;
            frame_cnt_q <= 10'd0;
          end else if (frame_cnt_q >= ME) begin
            state_q     <= RETRACT;
            collision   <= 1'b1;
            grabbed     <= 1'b0;
            frame_cnt_q <= 10'd0;
          end
        end
        RETRACT: begin
          if (home) begin
            state_q     <= DELIVER;
            score_valid <= grabbed;
            score_add   <= grabbed ? item_q : 8'd0;
            frame_cnt_q <= 10'd0;
          end else if (frame_cnt_q >= MR) begin
            state_q     <= IDLE;
            timeout_err <= 1'b1;
            grabbed     <= 1'b0;
            frame_cnt_q <= 10'd0;
          end
        end
        DELIVER: begin
          state_q     <= IDLE;
          grabbed     <= 1'b0;
          frame_cnt_q <= 10'd0;
        end
        default: begin
          state_q     <= IDLE;
          frame_cnt_q <= 10'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cable_launch_ctrl.sv
// tb_cable_launch_ctrl: directed checks of launch, hit, delivery, timeouts and reset
module tb_cable_launch_ctrl;
  logic               clk = 1'b0;
  logic               reset, startOfFrame, launch_key;
  logic signed [10:0] cableX, cableY;
  logic               drawReq_cable, drawReq_border, drawReq_item;
  logic [7:0]         item_value;
  logic               launch_Cable, collision, grabbed, score_valid, timeout_err;
  logic [7:0]         score_add;
  logic [2:0]         state_dbg;
  int n_cmp = 0;
  int n_err = 0;
  int cnt;
  always #5 clk = ~clk;
  cable_launch_ctrl dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .launch_key(launch_key),
    .cableX(cableX), .cableY(cableY), .drawReq_cable(drawReq_cable),
    .drawReq_border(drawReq_border), .drawReq_item(drawReq_item), .item_value(item_value),
    .launch_Cable(launch_Cable), .collision(collision), .grabbed(grabbed),
    .score_valid(score_valid), .score_add(score_add), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask
  task automatic launch_out(input string tag);
    launch_key = 1'b0;
    step();
    launch_key = 1'b1;
    step();
    check({tag, "_launch"}, state_dbg, 1);
    cableX = 11'sd290;
    step();
    launch_key = 1'b0;
    check({tag, "_extend"}, state_dbg, 2);
  endtask
  task automatic sof_hit(input string tag, input int exp_grab);
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    check({tag, "_coll"}, collision, 1);
    check({tag, "_grab"}, grabbed, exp_grab);
    check({tag, "_state"}, state_dbg, 3);
    step();
    check({tag, "_coll_end"}, collision, 0);
  endtask
  task automatic pixels(input logic b, input logic i, input logic [7:0] v, input int n);
    drawReq_cable = 1'b1;
    drawReq_border = b;
    drawReq_item = i;
    item_value = v;
    step(n);
    drawReq_cable = 1'b0;
    drawReq_border = 1'b0;
    drawReq_item = 1'b0;
    item_value = 8'd0;
    step();
  endtask
  initial begin
    reset = 1'b1; startOfFrame = 1'b0; launch_key = 1'b0;
    cableX = 11'sd280; cableY = 11'sd185;
    drawReq_cable = 1'b0; drawReq_border = 1'b0; drawReq_item = 1'b0; item_value = 8'd0;
    step(2);
    check("rst_state", state_dbg, 0);
    check("rst_outs", {launch_Cable, collision, grabbed, score_valid, timeout_err}, 0);
    check("rst_score", score_add, 0);
    reset = 1'b0;
    cableX = 11'sd290;
    launch_key = 1'b1;
    step();
    check("edge_off_home", state_dbg, 0);
    launch_key = 1'b0;
    cableX = 11'sd280;
    step();
    launch_key = 1'b1;
    step();
    check("launch_state", state_dbg, 1);
    check("launch_cable", launch_Cable, 1);
    step();
    check("launch_hold", launch_Cable, 1);
    cableX = 11'sd281;
    step();
    check("extend_state", state_dbg, 2);
    check("extend_cable", launch_Cable, 0);
    launch_key = 1'b0;
    pixels(1'b0, 1'b1, 8'h35, 3);
    check("no_coll_before_sof", collision, 0);
    sof_hit("item", 1);
    pixels(1'b1, 1'b1, 8'h11, 2);
    frame();
    check("retract_ignore", collision, 0);
    cableX = 11'sd280;
    step();
    check("deliver_state", state_dbg, 4);
    check("deliver_valid", score_valid, 1);
    check("deliver_add", score_add, 8'h35);
    step();
    check("idle_after", state_dbg, 0);
    check("grab_clear", grabbed, 0);
    check("valid_drop", score_valid, 0);
    check("add_zero", score_add, 0);
    launch_out("border");
    pixels(1'b1, 1'b0, 8'h00, 1);
    sof_hit("border", 0);
    cableX = 11'sd280;
    step();
    check("border_deliver", state_dbg, 4);
    check("border_no_score", score_valid, 0);
    step();
    check("border_idle", state_dbg, 0);
    launch_out("both");
    pixels(1'b1, 1'b1, 8'h5a, 1);
    sof_hit("both", 1);
    cableX = 11'sd280;
    step();
    check("both_add", score_add, 8'h5a);
    step();
    launch_key = 1'b0;
    step();
    launch_key = 1'b1;
    step();
    check("lto_launch", state_dbg, 1);
    repeat (3) frame();
    check("lto_wait", state_dbg, 1);
    frame();
    check("lto_idle", state_dbg, 0);
    check("lto_cable", launch_Cable, 0);
    launch_out("force");
    cnt = 0;
    for (int i = 0; i < 500; i++) begin
      frame();
      cnt++;
      if (collision) break;
    end
    check("force_frames", cnt, 400);
    check("force_grab", grabbed, 0);
    check("force_state", state_dbg, 3);
    cnt = 0;
    for (int i = 0; i < 500; i++) begin
      frame();
      cnt++;
      if (state_dbg == 3'd0) break;
    end
    check("rto_frames", cnt, 450);
    check("rto_err", timeout_err, 1);
    check("rto_grab", grabbed, 0);
    cableX = 11'sd280;
    launch_out("sticky");
    check("err_sticky", timeout_err, 1);
    reset = 1'b1;
    step();
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_outs", {launch_Cable, collision, grabbed, score_valid, timeout_err}, 0);
    reset = 1'b0;
    cableX = 11'sd280;
    step();
    launch_key = 1'b1;
    step();
    check("held_launch", state_dbg, 1);
    cableX = 11'sd290;
    step();
    pixels(1'b1, 1'b0, 8'h00, 1);
    sof_hit("held", 0);
    cableX = 11'sd280;
    step(2);
    check("held_idle", state_dbg, 0);
    step(3);
    check("held_no_relaunch", state_dbg, 0);
    launch_key = 1'b0;
    step();
    launch_key = 1'b1;
    step();
    check("repress_launch", state_dbg, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cable_launch_ctrl.md
Name: cable_launch_ctrl

Overview:
- Control-side counterpart of the cable mover. It launches the cable and watches the cable's pixel overlap with borders and gold items.
- It returns exactly one collision pulse per extension, so the mover reverses the cable.
- It latches a grabbed item and reports that item's value to the score logic once the cable is home.
- It sits between the keypad, the object drawing-request muxes and the cable mover / score counter.

Parameters:
- HOME_X, 280, cable home top-left X in pixels; must match the mover.
- HOME_Y, 185, cable home top-left Y in pixels.
- LAUNCH_TIMEOUT_FRAMES, 4, frames allowed for the cable to leave home.
- MAX_EXTEND_FRAMES, 400, frames before a forced return.
- MAX_RETRACT_FRAMES, 450, frames before a forced IDLE with error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- launch_key  in  1  level from keypad, high while pressed
- cableX  in  11 signed  cable topLeftX from mover
- cableY  in  11 signed  cable topLeftY from mover
- drawReq_cable  in  1  cable pixel active at current VGA pixel
- drawReq_border  in  1  border pixel active
- drawReq_item  in  1  gold/rock pixel active
- item_value  in  8  value of the item under the current pixel
- launch_Cable  out  1  launch request to mover
- collision  out  1  one-cycle reverse pulse to mover
- grabbed  out  1  an item is attached to the cable
- score_valid  out  1  one-cycle pulse, score_add is valid
- score_add  out  8  value of the delivered item
- timeout_err  out  1  sticky retract-timeout flag
- state_dbg  out  3  current FSM state encoding

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset).
- On reset: state=IDLE; all outputs 0; internal latches, frame counter and key_prev cleared.
- home = (cableX==HOME_X && cableY==HOME_Y), evaluated combinationally each cycle.
- States: IDLE=0, LAUNCH=1, EXTEND=2, RETRACT=3, DELIVER=4.
- IDLE:
  - A key rising edge (launch_key=1, key_prev=0) while home moves to LAUNCH.
  - A rising edge while not home is ignored.
- LAUNCH:
  - launch_Cable is held high every cycle in this state. The mover zeroes speed each home cycle unless launch_Cable is high.
  - When !home, go to EXTEND; launch_Cable drops that cycle.
  - If frame_cnt reaches LAUNCH_TIMEOUT_FRAMES, return to IDLE.
- EXTEND hit detection:
  - During each frame, set hit_item if drawReq_cable && drawReq_item; capture item_value on the first such pixel of the frame.
  - Set hit_border if drawReq_cable && drawReq_border.
  - Both latches clear on startOfFrame, after being sampled.
- EXTEND return:
  - On a startOfFrame cycle with hit_item or hit_border set, register collision=1 for exactly the next cycle and go to RETRACT.
  - If hit_item is set, grabbed<=1 and item_reg<=the captured value. An item hit has priority over a border hit in the same frame.
  - If frame_cnt reaches MAX_EXTEND_FRAMES, force the same collision pulse with grabbed=0.
- RETRACT:
  - No further collision pulses; overlap is ignored.
  - When home, go to DELIVER.
  - If frame_cnt reaches MAX_RETRACT_FRAMES, set timeout_err=1, clear grabbed, go to IDLE.
- DELIVER (1 cycle):
  - If grabbed, score_valid=1 and score_add=item_reg for this cycle.
  - Clear grabbed; go to IDLE.
  - score_add is 0 whenever score_valid=0.
- frame_cnt:
  - 10-bit counter; clears on every state change and increments on startOfFrame.
  - Saturates at 1023.
- Re-launch requires a fresh rising edge; holding the key through DELIVER does not relaunch.
- Reset mid-operation returns to IDLE at once with outputs 0. The mover is reset by the same event.
- timeout_err is cleared only by reset.

Test Plan:
- Cable at (280,185); pulse launch_key -> launch_Cable high from the cycle after the edge until cableX/Y != home, then state=EXTEND and launch_Cable=0.
- In EXTEND, cable overlaps an item of value 0x35 for 3 pixels -> at the next startOfFrame, collision is high for exactly 1 cycle and grabbed=1; state=RETRACT.
- Continue: cable returns to (280,185) -> one cycle of score_valid=1 with score_add=0x35, then grabbed=0 and state=IDLE.
- Border hit with no item -> one collision pulse, grabbed=0; at home, score_valid stays 0.
- Item and border both hit in the same frame -> a single collision pulse with grabbed=1.
- No overlap for 400 frames -> forced collision pulse.
- Hold cable off home in RETRACT for 450 frames -> timeout_err=1, state=IDLE.
- Assert reset in EXTEND -> all outputs 0 on the next cycle, state_dbg=0.
- Key held high through DELIVER -> no relaunch until the key is released and pressed again.
